// File: rtl/ifu_pkg.sv
// Shared types and decode helpers for the instruction fetch unit.
package ifu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fetch_entry_t;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Circular fetch-entry buffer with push/pop/clear and a registered entry count.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Storage carries data only, so it is left unreset; validity lives in count.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/ifu_fetchq.sv
// Fetch unit: PC generation with static prediction, redirect handling and a
// decoupling queue toward decode.
module ifu_fetchq
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter bit          PRED_BR  = 1'b1,
  parameter bit          PRED_JAL = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [31:0]                fetch_addr,
  input  logic                       fetch_hit,
  input  logic [31:0]                fetch_inst,
  input  logic                       jump_flush,
  input  logic [31:0]                jump_dnpc,
  input  logic                       cs_flush,
  input  logic [31:0]                cs_dnpc,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_pred,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {RUN, FLUSH_WAIT} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        dnpc_r;
  logic               flush;
  logic [31:0]        dnpc;
  logic               sel_br;
  logic               sel_jal;
  logic               pred;
  logic signed [31:0] incr;
  logic               push;
  logic               pop;
  logic               full;
  logic               has_head;
  logic [CW-1:0]      count;
  fetch_entry_t       head;
  fetch_entry_t       wdata;

  assign flush = cs_flush | jump_flush;
  assign dnpc  = cs_flush ? cs_dnpc : jump_dnpc;

  assign sel_br  = PRED_BR  && (fetch_inst[6:2] == OP_BRANCH) && fetch_inst[31];
  assign sel_jal = PRED_JAL && (fetch_inst[6:2] == OP_JAL);
  assign pred    = sel_br | sel_jal;

  always_comb begin
    incr = 32'sd4;
    if (sel_br)       incr = imm_b(fetch_inst);
    else if (sel_jal) incr = imm_j(fetch_inst);
  end

  assign has_head  = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = has_head & ~flush;
  assign pop       = out_valid & out_ready;
  assign push      = fetch_hit & ~flush & (state == RUN) & (~full | pop);
  assign wdata     = '{pc: fetch_pc, inst: fetch_inst, pred: pred};

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );

  // Redirect FSM: a flush during a miss must wait for that miss to return
  // at the old address before the new target can be fetched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      dnpc_r   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            if (fetch_hit) begin
              fetch_pc <= dnpc;
            end else begin
              state  <= FLUSH_WAIT;
              dnpc_r <= dnpc;
            end
          end else if (push) begin
            fetch_pc <= fetch_pc + $unsigned(incr);
          end
        end
        FLUSH_WAIT: begin
          if (fetch_hit) begin
            fetch_pc <= flush ? dnpc : dnpc_r;
            state    <= RUN;
          end else if (flush) begin
            dnpc_r <= dnpc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign fetch_addr = fetch_pc;
  assign occupancy  = count;
  assign out_pc     = has_head ? head.pc   : '0;
  assign out_inst   = has_head ? head.inst : '0;
  assign out_pred   = has_head ? head.pred : 1'b0;

endmodule
